serial_digit_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB first.
//  One DIGIT-wide full-adder slice is reused across cycles, with a registered carry between cycles. This trades latency for area.
//  Has valid/ready handshakes on input and output, so it can sit on a datapath stream between producer/consumer blocks.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/digit_adder.sv | 35 +++
 rtl/serial_digit_adder.sv | 143 ++++++++++++++
 tb/tb_serial_digit_adder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared state encoding and sizing helpers for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int n_dig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int width, input int digit);
    return ((width / digit) > 1) ? $clog2(width / digit) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit ripple-carry slice, exposing carry into the top bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
  end

  assign co    = w_c[DIGIT];
  assign c_top = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_digit_adder.sv
// ============================================================================
// Module      : serial_digit_adder
// Description : Multi-cycle add/subtract, DIGIT bits per clock LSB first, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int c_N_DIG = n_dig(WIDTH, DIGIT);
  localparam int c_CNT_W = cnt_w(WIDTH, DIGIT);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_digit_adder: DIGIT must be 1..WIDTH and divide WIDTH");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT-1:0]   w_s;
  logic               w_co;
  logic               w_ctop;
  logic [WIDTH-1:0]   w_res_next;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (r_opa[DIGIT-1:0]),
    .y     (r_opb[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_top (w_ctop)
  );

  assign w_last     = (r_cnt == c_CNT_W'(c_N_DIG - 1));
  // New digit enters at the top so the LSB digit lands at bit 0 after N_DIG steps
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_opa   <= r_opa >> DIGIT;
      r_opb   <= r_opb >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_co;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_co;
        r_ovf  <= w_co ^ w_ctop;
      end else begin
        r_cnt  <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
// ============================================================================
// Module      : tb_serial_digit_adder
// Description : Randomised bench for two adder configurations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_digit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin, sub, out_ready;
  logic       sel;

  logic       ir4, ov4, co4, of4, bz4;
  logic [7:0] s4;
  logic       ir8, ov8, co8, of8, bz8;
  logic [7:0] s8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .carry_out(co4), .overflow(of4), .busy(bz4)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir8),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready),
    .sum(s8), .carry_out(co8), .overflow(of8), .busy(bz8)
  );

  wire       w_ir  = sel ? ir8 : ir4;
  wire       w_ov  = sel ? ov8 : ov4;
  wire       w_co  = sel ? co8 : co4;
  wire       w_of  = sel ? of8 : of4;
  wire       w_bz  = sel ? bz8 : bz4;
  wire [7:0] w_sum = sel ? s8 : s4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {carry_out, overflow, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    int ux, uy, sx, sy, r, sr;
    logic co, ov;
    logic [7:0] rs;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      r  = ux + uy + int'(c);
      sr = sx + sy + int'(c);
      co = (r > 255);
    end else begin
      r  = ux - uy - int'(c);
      sr = sx - sy - int'(c);
      co = (r >= 0);
    end
    ov = (sr > 127) || (sr < -128);
    rs = r[7:0];
    return {co, ov, rs};
  endfunction

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input logic ts, input int hold, input string tag);
    logic [9:0] e;
    int lat;
    int exp_lat;
    e       = model(ta, tb_, tc, ts);
    exp_lat = sel ? 1 : 2;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(w_ir), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!w_ov && lat < 20) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".sum"}, 32'(w_sum), 32'(e[7:0]));
    chk({tag, ".carry_out"}, 32'(w_co), 32'(e[9]));
    chk({tag, ".overflow"}, 32'(w_of), 32'(e[8]));
    chk({tag, ".busy"}, 32'(w_bz), 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(w_ov), 32'd1);
      chk({tag, ".hold_sum"}, 32'({w_co, w_of, w_sum}), 32'(e));
      chk({tag, ".hold_in_ready"}, 32'(w_ir), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(w_ov), 32'd0);
    chk({tag, ".idle_ready"}, 32'(w_ir), 32'd1);
    chk({tag, ".idle_busy"}, 32'(w_bz), 32'd0);
    chk({tag, ".kept_result"}, 32'({w_co, w_of, w_sum}), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out4", 32'({ov4, bz4, ir4, co4, of4, s4}), 32'({5'b00100, 8'h00}));
    chk("rst.out8", 32'({ov8, bz8, ir8, co8, of8, s8}), 32'({5'b00100, 8'h00}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h3C, 8'h45, 1'b0, 1'b0, 0, "t1_add_ovf");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "t2_wrap");
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 0, "t3_sub_borrow");
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 5, "t4_backpressure");

    // Abort an operation with reset while it is in RUN
    a = 8'h7F; b = 8'h7F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5.busy_before", 32'(bz4), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5.after_rst", 32'({ov4, bz4, ir4, co4, of4, s4}), 32'({5'b00100, 8'h00}));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5.no_valid", 32'({ov4, bz4}), 32'd0);
    end

    sel = 1'b1;
    do_op(8'h7F, 8'h00, 1'b1, 1'b0, 0, "t6_single_digit");
    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), "rnd8");
    end

    sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "rnd4");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
